// File: rtl/frogger_pkg.sv
// Shared types and constants for the frog sprite engine.
//  color_t      : 6-bit RRGGBB pixel colour
//  dir_e        : latched hop direction
//  frog_state_e : frog controller state (IDLE / HOP / DEAD)
//  one_hot4     : true when exactly one bit of a 4-bit vector is set
package frogger_pkg;

    typedef logic [5:0] color_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOP  = 2'd1,
        DEAD = 2'd2
    } frog_state_e;

    localparam color_t COLOR_BLACK = 6'b000000;
    localparam color_t COLOR_WHITE = 6'b111111;

    function automatic logic one_hot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

endpackage

// File: rtl/frog_pixel_shader.sv
// Per-pixel colour decision for the frog layer, registered (1-cycle latency).
//  col_pos/row_pos  : current pixel
//  frog_x/frog_y    : frog top-left corner
//  frog_color       : colour the frog is drawn with this cycle (flash aware)
//  display_enable   : pixel column lies inside the playfield
//  color            : frog colour, grid colour or black
module frog_pixel_shader
    import frogger_pkg::*;
#(
    parameter int     COORD_W    = 10,
    parameter int     PLAY_X_MIN = 96,
    parameter int     PLAY_X_MAX = 544,
    parameter int     FROG_SIZE  = 32,
    parameter int     GRID_LOG2  = 5,
    parameter color_t GRID_COLOR = 6'b010101
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] col_pos,
    input  logic [COORD_W-1:0] row_pos,
    input  logic [COORD_W-1:0] frog_x,
    input  logic [COORD_W-1:0] frog_y,
    input  color_t             frog_color,
    output logic               display_enable,
    output color_t             color
);

    localparam int EXT_W = COORD_W + 1;
    localparam logic [EXT_W-1:0] SIZE_E  = EXT_W'(FROG_SIZE);
    localparam logic [EXT_W-1:0] X_MIN_E = EXT_W'(PLAY_X_MIN);
    localparam logic [EXT_W-1:0] X_MAX_E = EXT_W'(PLAY_X_MAX);

    logic [EXT_W-1:0] col_e_s, row_e_s, fx_e_s, fy_e_s;
    logic             in_play_s, in_frog_s, on_grid_s;
    logic             display_enable_d, display_enable_q;
    color_t           color_d, color_q;

    // Widen by one bit so frog_x + FROG_SIZE cannot wrap.
    assign col_e_s = {1'b0, col_pos};
    assign row_e_s = {1'b0, row_pos};
    assign fx_e_s  = {1'b0, frog_x};
    assign fy_e_s  = {1'b0, frog_y};

    // Classify the current pixel and pick its colour.
    always_comb begin
        in_play_s = (col_e_s >= X_MIN_E) && (col_e_s <= X_MAX_E);
        in_frog_s = (col_e_s >= fx_e_s) && (col_e_s < fx_e_s + SIZE_E) &&
                    (row_e_s >= fy_e_s) && (row_e_s < fy_e_s + SIZE_E);
        on_grid_s = (col_pos[GRID_LOG2-1:0] == GRID_LOG2'(0)) ||
                    (row_pos[GRID_LOG2-1:0] == GRID_LOG2'(0));
        display_enable_d = 1'b0;
        color_d          = COLOR_BLACK;
        if (!in_play_s) begin
            display_enable_d = 1'b0;
            color_d          = COLOR_BLACK;
        end else if (in_frog_s) begin
            display_enable_d = 1'b1;
            color_d          = frog_color;
        end else if (on_grid_s) begin
            display_enable_d = 1'b1;
            color_d          = GRID_COLOR;
        end else begin
            display_enable_d = 1'b1;
            color_d          = COLOR_BLACK;
        end
    end

    // Output register for the pixel decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display_enable_q <= 1'b0;
            color_q          <= COLOR_BLACK;
        end else begin
            display_enable_q <= display_enable_d;
            color_q          <= color_d;
        end
    end

    assign display_enable = display_enable_q;
    assign color          = color_q;

endmodule

// File: rtl/frog_sprite_engine.sv
// Frog sprite engine: frog position, animated hops, hit flashing/respawn,
// and per-pixel rendering of frog plus grid overlay.
//  frame_tick      : 1-cycle pulse at start of vertical blank (motion pacing)
//  hop_req         : one-hot {up,down,left,right}, sampled every cycle
//  hit             : 1-cycle collision pulse
//  colPos/rowPos   : current pixel
//  frog_x/frog_y   : frog top-left, registered
//  hop_busy        : high while hopping or dead
//  display_enable  : pixel valid, registered
//  color           : pixel colour (RRGGBB), registered
module frog_sprite_engine
    import frogger_pkg::*;
#(
    parameter int     COORD_W      = 10,
    parameter int     PLAY_X_MIN   = 96,
    parameter int     PLAY_X_MAX   = 544,
    parameter int     PLAY_Y_MIN   = 0,
    parameter int     PLAY_Y_MAX   = 480,
    parameter int     FROG_SIZE    = 32,
    parameter int     X_START      = 304,
    parameter int     Y_START      = 448,
    parameter int     HOP_STEP     = 32,
    parameter int     HOP_FRAMES   = 4,
    parameter int     GRID_LOG2    = 5,
    parameter int     FLASH_FRAMES = 16,
    parameter color_t FROG_COLOR   = 6'b001100,
    parameter color_t GRID_COLOR   = 6'b010101
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic [3:0]         hop_req,
    input  logic               hit,
    input  logic [COORD_W-1:0] colPos,
    input  logic [COORD_W-1:0] rowPos,
    output logic [COORD_W-1:0] frog_x,
    output logic [COORD_W-1:0] frog_y,
    output logic               hop_busy,
    output logic               display_enable,
    output color_t             color
);

    localparam int CNT_MAX = (FLASH_FRAMES > HOP_FRAMES) ? FLASH_FRAMES : HOP_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    // Extra bits plus sign so a rejected target (e.g. above row 0) stays negative.
    localparam int EXT_W   = COORD_W + 3;

    localparam logic [COORD_W-1:0] X_START_C = COORD_W'(X_START);
    localparam logic [COORD_W-1:0] Y_START_C = COORD_W'(Y_START);
    localparam logic [COORD_W-1:0] STEP_C    = COORD_W'(HOP_STEP / HOP_FRAMES);
    localparam logic [CNT_W-1:0]   FLASH_C   = CNT_W'(FLASH_FRAMES);
    localparam logic [CNT_W-1:0]   LAST_HOP  = CNT_W'(HOP_FRAMES - 1);

    localparam logic signed [EXT_W-1:0] HOP_E   = EXT_W'(HOP_STEP);
    localparam logic signed [EXT_W-1:0] SIZE_E  = EXT_W'(FROG_SIZE);
    localparam logic signed [EXT_W-1:0] ONE_E   = EXT_W'(1);
    localparam logic signed [EXT_W-1:0] X_MIN_E = EXT_W'(PLAY_X_MIN);
    localparam logic signed [EXT_W-1:0] X_MAX_E = EXT_W'(PLAY_X_MAX);
    localparam logic signed [EXT_W-1:0] Y_MIN_E = EXT_W'(PLAY_Y_MIN);
    localparam logic signed [EXT_W-1:0] Y_MAX_E = EXT_W'(PLAY_Y_MAX);

    frog_state_e        state_d, state_q;
    dir_e               dir_d, dir_q;
    logic [COORD_W-1:0] x_d, x_q, y_d, y_q;
    logic [CNT_W-1:0]   cnt_d, cnt_q;
    logic               phase_d, phase_q;
    logic               hop_busy_d, hop_busy_q;

    logic signed [EXT_W-1:0] tgt_x_s, tgt_y_s;
    dir_e                    req_dir_s;
    logic                    req_ok_s;
    color_t                  frog_color_s;

    // Candidate hop target and whether it keeps the whole frog on the playfield.
    always_comb begin
        tgt_x_s   = signed'({3'b000, x_q});
        tgt_y_s   = signed'({3'b000, y_q});
        req_dir_s = DIR_UP;
        case (hop_req)
            4'b1000: begin tgt_y_s = tgt_y_s - HOP_E; req_dir_s = DIR_UP;    end
            4'b0100: begin tgt_y_s = tgt_y_s + HOP_E; req_dir_s = DIR_DOWN;  end
            4'b0010: begin tgt_x_s = tgt_x_s - HOP_E; req_dir_s = DIR_LEFT;  end
            4'b0001: begin tgt_x_s = tgt_x_s + HOP_E; req_dir_s = DIR_RIGHT; end
            default: begin req_dir_s = DIR_UP; end
        endcase
        req_ok_s = one_hot4(hop_req) &&
                   (tgt_x_s >= X_MIN_E) && (tgt_x_s + SIZE_E - ONE_E <= X_MAX_E) &&
                   (tgt_y_s >= Y_MIN_E) && (tgt_y_s + SIZE_E <= Y_MAX_E);
    end

    // Controller next-state: hit beats a frame step, which beats a hop request.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d = DEAD;
                    cnt_d   = FLASH_C;
                    phase_d = 1'b0;
                end else if (req_ok_s) begin
                    state_d = HOP;
                    dir_d   = req_dir_s;
                    cnt_d   = CNT_W'(0);
                end else begin
                    state_d = IDLE;
                end
            end
            HOP: begin
                if (hit) begin
                    state_d = DEAD;
                    cnt_d   = FLASH_C;
                    phase_d = 1'b0;
                end else if (frame_tick) begin
                    case (dir_q)
                        DIR_UP:    y_d = y_q - STEP_C;
                        DIR_DOWN:  y_d = y_q + STEP_C;
                        DIR_LEFT:  x_d = x_q - STEP_C;
                        DIR_RIGHT: x_d = x_q + STEP_C;
                        default:   x_d = x_q;
                    endcase
                    if (cnt_q == LAST_HOP) begin
                        state_d = IDLE;
                        cnt_d   = CNT_W'(0);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = HOP;
                end
            end
            DEAD: begin
                // A hit while dead does not restart the flash.
                if (frame_tick) begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = IDLE;
                        x_d     = X_START_C;
                        y_d     = Y_START_C;
                        cnt_d   = CNT_W'(0);
                        phase_d = 1'b0;
                    end else begin
                        cnt_d   = cnt_q - CNT_W'(1);
                        phase_d = ~phase_q;
                    end
                end else begin
                    state_d = DEAD;
                end
            end
            default: begin
                state_d = IDLE;
                x_d     = X_START_C;
                y_d     = Y_START_C;
                cnt_d   = CNT_W'(0);
                phase_d = 1'b0;
            end
        endcase
        hop_busy_d = (state_d != IDLE);
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            dir_q      <= DIR_UP;
            x_q        <= X_START_C;
            y_q        <= Y_START_C;
            cnt_q      <= CNT_W'(0);
            phase_q    <= 1'b0;
            hop_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            x_q        <= x_d;
            y_q        <= y_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            hop_busy_q <= hop_busy_d;
        end
    end

    // Flash alternates frog colour and white while dead, starting with frog colour.
    assign frog_color_s = ((state_q == DEAD) && phase_q) ? COLOR_WHITE : FROG_COLOR;

    assign frog_x   = x_q;
    assign frog_y   = y_q;
    assign hop_busy = hop_busy_q;

    frog_pixel_shader #(
        .COORD_W    (COORD_W),
        .PLAY_X_MIN (PLAY_X_MIN),
        .PLAY_X_MAX (PLAY_X_MAX),
        .FROG_SIZE  (FROG_SIZE),
        .GRID_LOG2  (GRID_LOG2),
        .GRID_COLOR (GRID_COLOR)
    ) u_shader (
        .clk            (clk),
        .rst_n          (rst_n),
        .col_pos        (colPos),
        .row_pos        (rowPos),
        .frog_x         (x_q),
        .frog_y         (y_q),
        .frog_color     (frog_color_s),
        .display_enable (display_enable),
        .color          (color)
    );

endmodule
